// File: rtl/decim_pkg.sv
// Shared definitions for frame_decimator: FSM state encoding plus the block-size helpers
// that fix the accumulator width and the fixed-point reciprocal used for averaging.
package decim_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_WAIT_VS_HI = 3'd1;
    localparam state_t ST_WAIT_VS_LO = 3'd2;
    localparam state_t ST_HBLANK     = 3'd3;
    localparam state_t ST_LINE       = 3'd4;
    localparam state_t ST_FLUSH      = 3'd5;
    localparam state_t ST_DONE       = 3'd6;

    function automatic int acc_width(input int n_pix);
        return 8 + $clog2(n_pix);
    endfunction

    // round(65536 / n_pix) in integer arithmetic
    function automatic int recip(input int n_pix);
        return (65536 + n_pix / 2) / n_pix;
    endfunction

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; head reads as zero while empty so the output bus
// stays quiet after reset.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 32
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_fire, rd_fire;

    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        wr_fire  = wr_en && !full;
        rd_fire  = rd_en && !empty;
        wr_ptr_d = wr_ptr_q + (AW+1)'(wr_fire);
        rd_ptr_d = rd_ptr_q + (AW+1)'(rd_fire);
        rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/frame_decimator.sv
// Camera frame decimator: averages the luma byte over BLK_W x BLK_H blocks and streams one
// byte per block. Define DECIM_ROUND_EN for round-to-nearest averaging (default truncates).
module frame_decimator
    import decim_pkg::*;
#(
    parameter int IMG_W         = 640,
    parameter int IMG_H         = 480,
    parameter int BLK_W         = 40,
    parameter int BLK_H         = 30,
    parameter int BYTES_PER_PIX = 2,
    parameter int LUMA_BYTE     = 1,
    parameter int FIFO_DEPTH    = 32
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       start,
    input  logic       vsync,
    input  logic       href,
    input  logic [7:0] d,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy,
    output logic       done,
    output logic       overflow,
    output logic       frame_err
);
    localparam int NBX    = IMG_W / BLK_W;
    localparam int NBANDS = IMG_H / BLK_H;
    localparam int NPIX   = BLK_W * BLK_H;
    localparam int ACC_W  = acc_width(NPIX);
    localparam int RECIP  = recip(NPIX);
    localparam int BXW    = idx_width(NBX);
    localparam int PW     = idx_width(BLK_W);
    localparam int LW     = idx_width(BLK_H);
    localparam int BDW    = idx_width(NBANDS);
    localparam int CW     = $clog2(IMG_W + 1);
    localparam int PROD_W = ACC_W + 17;

    state_t             state_q, state_d;
    logic               phase_q, phase_d;
    logic [CW-1:0]      col_q, col_d;
    logic [PW-1:0]      pix_q, pix_d;
    logic [BXW-1:0]     blk_q, blk_d;
    logic [LW-1:0]      line_q, line_d;
    logic [BDW-1:0]     band_q, band_d;
    logic               vsync_q, vsync_d;
    logic [ACC_W-1:0]   acc_q [NBX];
    logic [ACC_W-1:0]   acc_d [NBX];
    logic [ACC_W-1:0]   snap_q [NBX];
    logic [ACC_W-1:0]   snap_d [NBX];
    logic [BXW-1:0]     drain_cnt_q, drain_cnt_d;
    logic               drain_act_q, drain_act_d;
    logic               snap_last_q, snap_last_d;
    logic               overflow_q, overflow_d;
    logic               frame_err_q, frame_err_d;

    logic               byte_en, cur_phase, clear_acc, drain_at_end, band_at_end;
    logic [PROD_W-1:0]  prod, quot;
    logic [7:0]         avg;
    logic               fifo_wr, fifo_full, fifo_empty;
    logic [8:0]         fifo_wdata, fifo_rdata;

    always_comb begin
        prod = PROD_W'(snap_q[drain_cnt_q]) * PROD_W'(RECIP);
`ifdef DECIM_ROUND_EN
        prod = prod + PROD_W'(32768);
`endif
        quot = prod >> 16;
        avg  = (|quot[PROD_W-1:8]) ? 8'hFF : quot[7:0];
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        col_d       = col_q;
        pix_d       = pix_q;
        blk_d       = blk_q;
        line_d      = line_q;
        band_d      = band_q;
        vsync_d     = vsync;
        acc_d       = acc_q;
        snap_d      = snap_q;
        drain_cnt_d = drain_cnt_q;
        drain_act_d = drain_act_q;
        snap_last_d = snap_last_q;
        overflow_d  = overflow_q;
        frame_err_d = frame_err_q;
        byte_en     = 1'b0;
        clear_acc   = 1'b0;
        cur_phase   = (state_q == ST_LINE) ? phase_q : 1'b0;
        drain_at_end = (drain_cnt_q == BXW'(NBX - 1));
        band_at_end  = (band_q == BDW'(NBANDS - 1));
        fifo_wr     = 1'b0;

        if (drain_act_q) begin
            fifo_wr = 1'b1;
            if (fifo_full) overflow_d = 1'b1;
            if (drain_at_end) drain_act_d = 1'b0;
            else              drain_cnt_d = drain_cnt_q + BXW'(1);
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_WAIT_VS_HI;
                    overflow_d  = 1'b0;
                    frame_err_d = 1'b0;
                    clear_acc   = 1'b1;
                end
            end
            ST_WAIT_VS_HI: if (vsync) state_d = ST_WAIT_VS_LO;
            ST_WAIT_VS_LO: begin
                if (!vsync) begin
                    state_d = ST_HBLANK;
                    line_d  = '0;
                    band_d  = '0;
                    col_d   = '0;
                    pix_d   = '0;
                    blk_d   = '0;
                    phase_d = 1'b0;
                end
            end
            ST_HBLANK, ST_LINE: begin
                if (vsync && !vsync_q) begin
                    // early vsync: the partial band is thrown away
                    frame_err_d = 1'b1;
                    clear_acc   = 1'b1;
                    state_d     = ST_FLUSH;
                end else if (href) begin
                    state_d = ST_LINE;
                    byte_en = 1'b1;
                end else if (state_q == ST_LINE) begin
                    state_d = ST_HBLANK;
                    col_d   = '0;
                    pix_d   = '0;
                    blk_d   = '0;
                    phase_d = 1'b0;
                    if (line_q == LW'(BLK_H - 1)) begin
                        line_d    = '0;
                        snap_d    = acc_q;
                        clear_acc = 1'b1;
                        if (drain_act_q && !drain_at_end) overflow_d = 1'b1;
                        drain_act_d = 1'b1;
                        drain_cnt_d = '0;
                        snap_last_d = band_at_end;
                        if (band_at_end) state_d = ST_FLUSH;
                        else             band_d  = band_q + BDW'(1);
                    end else begin
                        line_d = line_q + LW'(1);
                    end
                end
            end
            ST_FLUSH: if (!drain_act_q) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase

        if (byte_en) begin
            phase_d = (BYTES_PER_PIX == 2) ? ~cur_phase : 1'b0;
            if (cur_phase == 1'(LUMA_BYTE) && col_q < CW'(IMG_W)) begin
                acc_d[blk_q] = acc_q[blk_q] + ACC_W'(d);
                col_d        = col_q + CW'(1);
                if (pix_q == PW'(BLK_W - 1)) begin
                    pix_d = '0;
                    blk_d = blk_q + BXW'(1);
                end else begin
                    pix_d = pix_q + PW'(1);
                end
            end
        end

        if (clear_acc) begin
            for (int i = 0; i < NBX; i++) acc_d[i] = '0;
        end

        fifo_wdata = {snap_last_q && drain_at_end, avg};
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= 1'b0;
            col_q       <= '0;
            pix_q       <= '0;
            blk_q       <= '0;
            line_q      <= '0;
            band_q      <= '0;
            vsync_q     <= 1'b0;
            acc_q       <= '{default: '0};
            snap_q      <= '{default: '0};
            drain_cnt_q <= '0;
            drain_act_q <= 1'b0;
            snap_last_q <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            col_q       <= col_d;
            pix_q       <= pix_d;
            blk_q       <= blk_d;
            line_q      <= line_d;
            band_q      <= band_d;
            vsync_q     <= vsync_d;
            acc_q       <= acc_d;
            snap_q      <= snap_d;
            drain_cnt_q <= drain_cnt_d;
            drain_act_q <= drain_act_d;
            snap_last_q <= snap_last_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    sync_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .pclk    (pclk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (out_ready),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rdata[7:0];
    assign out_last  = fifo_rdata[8];
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_frame_decimator.sv
// Directed bench for frame_decimator on an 8x4 image with 4x2 blocks; a second instance
// with a 2-entry FIFO exercises overflow. Honours DECIM_ROUND_EN for the rounding case.
module tb_frame_decimator;
    logic       pclk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       vsync = 1'b0;
    logic       href = 1'b0;
    logic [7:0] d = 8'h00;
    logic       out_ready = 1'b1;
    logic       out_ready2 = 1'b1;

    logic       out_valid, out_last, busy, done, overflow, frame_err;
    logic [7:0] out_data;
    logic       out_valid2, out_last2, busy2, done2, overflow2, frame_err2;
    logic [7:0] out_data2;

    int errors = 0;
    int checks = 0;
    logic [8:0] q1 [$];
    logic [8:0] q2 [$];

    always #5 pclk = ~pclk;

    frame_decimator #(
        .IMG_W(8), .IMG_H(4), .BLK_W(4), .BLK_H(2),
        .BYTES_PER_PIX(2), .LUMA_BYTE(1), .FIFO_DEPTH(4)
    ) dut (
        .pclk(pclk), .reset(reset), .start(start), .vsync(vsync), .href(href), .d(d),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .overflow(overflow), .frame_err(frame_err)
    );

    frame_decimator #(
        .IMG_W(8), .IMG_H(4), .BLK_W(4), .BLK_H(2),
        .BYTES_PER_PIX(2), .LUMA_BYTE(1), .FIFO_DEPTH(2)
    ) dut2 (
        .pclk(pclk), .reset(reset), .start(start), .vsync(vsync), .href(href), .d(d),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_last(out_last2),
        .busy(busy2), .done(done2), .overflow(overflow2), .frame_err(frame_err2)
    );

    always @(negedge pclk) begin
        if (!reset) begin
            if (out_valid && out_ready)   q1.push_back({out_last, out_data});
            if (out_valid2 && out_ready2) q2.push_back({out_last2, out_data2});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    function automatic logic [7:0] luma(input int mode, input int ln, input int col);
        case (mode)
            0:       return 8'h80;
            1:       return (col < 4) ? 8'h10 : 8'hF0;
            default: return (ln == 0 && col == 0) ? 8'd12 : ((ln < 2 && col < 4) ? 8'd0 : 8'h40);
        endcase
    endfunction

    task automatic start_frame();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        vsync = 1'b1;
        tick(3);
        vsync = 1'b0;
        tick(3);
    endtask

    task automatic drive_line(input int mode, input int ln, input int npix);
        for (int c = 0; c < npix; c++) begin
            href = 1'b1;
            d    = 8'h55;
            tick(1);
            d    = luma(mode, ln, c);
            tick(1);
        end
        href = 1'b0;
        d    = 8'h00;
        tick(4);
    endtask

    task automatic wait_done1(output bit ok);
        int n = 0;
        while (!done && n < 200) begin
            tick(1);
            n++;
        end
        ok = done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++;
        if ({out_valid, out_last, busy, done, overflow, frame_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b want=000000", {out_valid, out_last, busy, done, overflow, frame_err});
        end
        checks++;
        if (out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got=%h want=00", out_data);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_uniform();
        bit ok;
        q1.delete();
        start_frame();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL uniform_busy got=%b want=1", busy);
        end
        for (int ln = 0; ln < 4; ln++) drive_line(0, ln, 8);
        wait_done1(ok);
        tick(8);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL uniform_done_timeout got=0 want=1");
        end
        checks++;
        if (q1.size() != 4) begin
            errors++;
            $display("FAIL uniform_count got=%0d want=4", q1.size());
        end
        for (int i = 0; i < 4; i++) begin
            logic [8:0] got;
            logic [8:0] want;
            got  = (i < q1.size()) ? q1[i] : 9'h1FF;
            want = {(i == 3) ? 1'b1 : 1'b0, 8'h80};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL uniform_out%0d got=%h want=%h", i, got, want);
            end
        end
        checks++;
        if ({done, busy, overflow, frame_err} !== 4'b1000) begin
            errors++;
            $display("FAIL uniform_status got=%b want=1000", {done, busy, overflow, frame_err});
        end
    endtask

    task automatic test_split();
        bit ok;
        logic [7:0] want [4];
        want = '{8'h10, 8'hF0, 8'h10, 8'hF0};
        q1.delete();
        start_frame();
        for (int ln = 0; ln < 4; ln++) drive_line(1, ln, 8);
        wait_done1(ok);
        tick(8);
        checks++;
        if (q1.size() != 4) begin
            errors++;
            $display("FAIL split_count got=%0d want=4", q1.size());
        end
        for (int i = 0; i < 4; i++) begin
            logic [8:0] got;
            got = (i < q1.size()) ? q1[i] : 9'h1FF;
            checks++;
            if (got !== {(i == 3) ? 1'b1 : 1'b0, want[i]}) begin
                errors++;
                $display("FAIL split_out%0d got=%h want=%h", i, got, {(i == 3) ? 1'b1 : 1'b0, want[i]});
            end
        end
    endtask

    task automatic test_rounding();
        bit ok;
        logic [7:0] want [4];
`ifdef DECIM_ROUND_EN
        want = '{8'd2, 8'h40, 8'h40, 8'h40};
`else
        want = '{8'd1, 8'h40, 8'h40, 8'h40};
`endif
        q1.delete();
        start_frame();
        for (int ln = 0; ln < 4; ln++) drive_line(2, ln, 8);
        wait_done1(ok);
        tick(8);
        checks++;
        if (q1.size() != 4) begin
            errors++;
            $display("FAIL round_count got=%0d want=4", q1.size());
        end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] got;
            got = (i < q1.size()) ? q1[i][7:0] : 8'hEE;
            checks++;
            if (got !== want[i]) begin
                errors++;
                $display("FAIL round_out%0d got=%h want=%h", i, got, want[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int n = 0;
        out_ready2 = 1'b0;
        q1.delete();
        start_frame();
        for (int ln = 0; ln < 4; ln++) drive_line(0, ln, 8);
        while (!done2 && n < 200) begin
            tick(1);
            n++;
        end
        checks++;
        if (done2 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_done_timeout got=%b want=1", done2);
        end
        checks++;
        if (overflow2 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag got=%b want=1", overflow2);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_deep_fifo got=%b want=0", overflow);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({out_valid2, out_data2} !== {1'b1, 8'h80}) begin
                errors++;
                $display("FAIL ovf_hold%0d got=%b/%h want=1/80", k, out_valid2, out_data2);
            end
            tick(1);
        end
        q2.delete();
        out_ready2 = 1'b1;
        tick(10);
        checks++;
        if (q2.size() != 2) begin
            errors++;
            $display("FAIL ovf_count got=%0d want=2", q2.size());
        end
        for (int i = 0; i < 2; i++) begin
            logic [8:0] got;
            got = (i < q2.size()) ? q2[i] : 9'h1FF;
            checks++;
            if (got !== 9'h080) begin
                errors++;
                $display("FAIL ovf_out%0d got=%h want=080", i, got);
            end
        end
    endtask

    task automatic test_frame_err();
        bit ok;
        q1.delete();
        start_frame();
        drive_line(0, 0, 8);
        drive_line(0, 1, 8);
        vsync = 1'b1;
        tick(2);
        vsync = 1'b0;
        wait_done1(ok);
        tick(8);
        checks++;
        if ({ok, done, frame_err} !== 3'b111) begin
            errors++;
            $display("FAIL ferr_status got=%b want=111", {ok, done, frame_err});
        end
        checks++;
        if (q1.size() != 2) begin
            errors++;
            $display("FAIL ferr_count got=%0d want=2", q1.size());
        end
        for (int i = 0; i < 2; i++) begin
            logic [8:0] got;
            got = (i < q1.size()) ? q1[i] : 9'h1FF;
            checks++;
            if (got !== 9'h080) begin
                errors++;
                $display("FAIL ferr_out%0d got=%h want=080", i, got);
            end
        end
        start = 1'b1;
        tick(1);
        start = 1'b0;
        checks++;
        if ({frame_err, busy, done} !== 3'b010) begin
            errors++;
            $display("FAIL ferr_restart got=%b want=010", {frame_err, busy, done});
        end
    endtask

    task automatic test_reset_midline();
        bit ok;
        out_ready = 1'b0;
        start_frame();
        drive_line(0, 0, 8);
        drive_line(0, 1, 8);
        drive_line(0, 2, 3);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_prevalid got=%b want=1", out_valid);
        end
        href = 1'b1;
        d    = 8'h55;
        tick(1);
        reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_last, busy, done, overflow, frame_err, out_data} !== 14'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs got=%b want=0", {out_valid, out_last, busy, done, overflow, frame_err, out_data});
        end
        href = 1'b0;
        d    = 8'h00;
        tick(2);
        reset = 1'b0;
        out_ready = 1'b1;
        tick(2);
        q1.delete();
        start_frame();
        for (int ln = 0; ln < 4; ln++) drive_line(0, ln, 8);
        wait_done1(ok);
        tick(8);
        checks++;
        if ({ok, done, overflow, frame_err} !== 4'b1100) begin
            errors++;
            $display("FAIL rst_mid_status got=%b want=1100", {ok, done, overflow, frame_err});
        end
        checks++;
        if (q1.size() != 4) begin
            errors++;
            $display("FAIL rst_mid_count got=%0d want=4", q1.size());
        end
        for (int i = 0; i < 4; i++) begin
            logic [8:0] got;
            got = (i < q1.size()) ? q1[i] : 9'h1FF;
            checks++;
            if (got !== {(i == 3) ? 1'b1 : 1'b0, 8'h80}) begin
                errors++;
                $display("FAIL rst_mid_out%0d got=%h want=%h", i, got, {(i == 3) ? 1'b1 : 1'b0, 8'h80});
            end
        end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_split();
        test_rounding();
        test_overflow();
        test_frame_err();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
